// File: rtl/sha256_pkg.sv
// Shared widths, types and helpers for the SHA-256 message padding path.
package sha256_pkg;

  localparam int MSG_W   = 1024;
  localparam int LEN_W   = 10;
  localparam int BLK_W   = 512;
  localparam int MAX_BLK = 3;
  localparam int IDX_W   = 2;

  typedef logic [0:BLK_W-1] block_t;
  typedef logic [0:MSG_W-1] msg_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } padder_state_t;

  // Blocks needed for L message bits plus the pad bit and 64-bit length field.
  function automatic logic [IDX_W-1:0] calc_nblk(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(64);
    return sum[LEN_W:9] + 2'd1;
  endfunction

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational builder for block k of the padded stream of a message of length len.
module sha256_pad_block
  import sha256_pkg::*;
(
  input  msg_t             msg_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [IDX_W-1:0] k_i,
  input  logic [IDX_W-1:0] nblk_i,
  output block_t           blk_o
);

  logic is_last;

  assign is_last = (k_i == nblk_i - 2'd1);

  always_comb begin
    logic [LEN_W:0] pos;
    blk_o = '0;
    for (int j = 0; j < BLK_W; j++) begin
      pos = {k_i, 9'(j)};
      // Message bits at or beyond len are masked; the pad bit sits exactly at len.
      if (pos < {1'b0, len_i}) begin
        blk_o[j] = msg_i[pos[LEN_W-1:0]];
      end else if (pos == {1'b0, len_i}) begin
        blk_o[j] = 1'b1;
      end
    end
    // Length field: big-endian 64-bit value whose upper 54 bits are always zero.
    if (is_last) begin
      blk_o[BLK_W-LEN_W +: LEN_W] = len_i;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Accepts one message, applies FIPS 180-4 padding and streams the padded 512-bit blocks.
// Both interfaces are valid/ready: a transfer happens on a rising edge where valid && ready,
// and the producer holds its payload stable while valid is high and ready is low.
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [LEN_W-1:0] input_length,
  input  logic [0:MSG_W-1] binary_input,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [0:BLK_W-1] blk_data,
  output logic             blk_first,
  output logic             blk_last,
  output logic [IDX_W-1:0] blk_idx,
  output padder_state_t    dbg_state_o
);

  padder_state_t    state_q, state_d;
  msg_t             msg_q, msg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] nblk_q, nblk_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  block_t           data_q, data_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  msg_t             pad_msg;
  logic [LEN_W-1:0] pad_len;
  logic [IDX_W-1:0] pad_k;
  logic [IDX_W-1:0] pad_nblk;
  logic [IDX_W-1:0] in_nblk;
  logic [IDX_W-1:0] idx_nxt;
  block_t           pad_blk;

  assign in_nblk = calc_nblk(input_length);
  assign idx_nxt = idx_q + 2'd1;

  // One builder serves both block 0 (from the live inputs) and the following blocks.
  always_comb begin
    if (state_q == IDLE) begin
      pad_msg  = binary_input;
      pad_len  = input_length;
      pad_k    = '0;
      pad_nblk = in_nblk;
    end else begin
      pad_msg  = msg_q;
      pad_len  = len_q;
      pad_k    = idx_nxt;
      pad_nblk = nblk_q;
    end
  end

  sha256_pad_block u_pad_block (
    .msg_i  (pad_msg),
    .len_i  (pad_len),
    .k_i    (pad_k),
    .nblk_i (pad_nblk),
    .blk_o  (pad_blk)
  );

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    len_d   = len_q;
    nblk_d  = nblk_q;
    idx_d   = idx_q;
    data_d  = data_q;
    first_d = first_q;
    last_d  = last_q;
    valid_d = valid_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          state_d = EMIT;
          msg_d   = binary_input;
          len_d   = input_length;
          nblk_d  = in_nblk;
          idx_d   = '0;
          data_d  = pad_blk;
          first_d = 1'b1;
          last_d  = (in_nblk == 2'd1);
          valid_d = 1'b1;
          ready_d = 1'b0;
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            idx_d   = idx_nxt;
            data_d  = pad_blk;
            first_d = 1'b0;
            last_d  = (idx_nxt == nblk_q - 2'd1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      len_q   <= '0;
      nblk_q  <= 2'd1;
      idx_q   <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      nblk_q  <= nblk_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      first_q <= first_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign msg_ready   = ready_q;
  assign blk_valid   = valid_q;
  assign blk_data    = data_q;
  assign blk_first   = first_q;
  assign blk_last    = last_q;
  assign blk_idx     = idx_q;
  assign dbg_state_o = state_q;

endmodule
